rsa_exp_ctrl: RTL and testbench
===============================

# rsa_exp_ctrl

Sequencer for the modular-exponentiation datapath behind the RSA command wrapper. On `start` it captures the exponent and its bit length, then walks the exponent MSB-first. It issues one Montgomery-multiplier operation at a time (to-Montgomery conversion, square, multiply, from-Montgomery conversion) and tells the datapath which operand pair to use and where to write the result. It sits between the wrapper's compute state and a multi-cycle Montgomery multiplier plus its operand registers.

## Interface
- `N_BITS`, default 1024: exponent width.
- `LEN_W`, default 11: width of the bit-length field; must hold `N_BITS`.
- `clk` in 1: single clock, rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request; sampled only in IDLE.
- `exp` in `N_BITS`: exponent; captured on accepted `start`.
- `exp_len` in `LEN_W`: number of exponent bits to process, 0..`N_BITS`; captured with `exp`.
- `busy` out 1: operation in progress.
- `done` out 1: one-cycle pulse; result valid in datapath register A.
- `a_init` out 1: one-cycle pulse; datapath loads A <= R mod M.
- `mm_start` out 1: one-cycle pulse; launches the multiplier.
- `mm_op` out 2: operation code; held stable from `mm_start` through `mm_done`.
- `mm_done` in 1: one-cycle pulse from the multiplier; datapath writes the result selected by `mm_op`.
- `bit_idx` out `LEN_W`: current exponent bit index (debug/LEDs).

## Operation
- `mm_op` encoding:
  - TO_MONT=0: Xt <= MM(X, R²).
  - SQUARE=1: A <= MM(A, A).
  - MULT=2: A <= MM(A, Xt).
  - FROM_MONT=3: A <= MM(A, 1).
- States: IDLE, TOM_WAIT, SQ_WAIT, MUL_WAIT, FROM_WAIT, DONE.
- IDLE with `start`=1:
  - capture `exp` into `exp_q`; set `bit_idx` <= `exp_len`-1;
  - register `a_init`=1, `mm_start`=1, `mm_op`=TO_MONT;
  - go to TOM_WAIT.
- TOM_WAIT on `mm_done`:
  - if `exp_len`=0, issue FROM_MONT and go to FROM_WAIT;
  - otherwise issue SQUARE and go to SQ_WAIT.
- SQ_WAIT on `mm_done`:
  - if `exp_q[bit_idx]`=1, issue MULT and go to MUL_WAIT;
  - otherwise perform step-bit.
- MUL_WAIT on `mm_done`: perform step-bit.
- Step-bit:
  - if `bit_idx`=0, issue FROM_MONT and go to FROM_WAIT;
  - otherwise decrement `bit_idx`, issue SQUARE, and go to SQ_WAIT.
- FROM_WAIT on `mm_done`: go to DONE.
- DONE: `done`=1 for that cycle; return to IDLE.
- Number of operations = 2 + `exp_len` + popcount(`exp_q[exp_len-1:0]`).
- `exp_len`=0 gives exactly 2 operations, so the result is 1 (x⁰).
- `exp_len` > `N_BITS` is clamped to `N_BITS`.
- `start` outside IDLE is ignored.
- `mm_done` outside a *_WAIT state is ignored, and causes no state or output change.
- `exp` and `exp_len` may change freely after capture.

## Timing
- Reset values:
  - all outputs 0, `mm_op`=0, `bit_idx`=0;
  - state IDLE; `exp_q` cleared.
- Reset is asynchronous. Reset asserted mid-operation aborts immediately with no `done`. The multiplier shares `resetn`.
- All outputs are registered.
- `start` sampled at edge t → `a_init`, `mm_start` and `busy` are high in cycle t+1.
- `mm_done` sampled at edge u → next `mm_start` (or `done`) is high in cycle u+1. There is one bubble per operation.
- `busy` is high from the first `mm_start` cycle through the `done` cycle inclusive, and low in IDLE.
- Back-to-back jobs: `start` sampled in the cycle after `done` is accepted.
- Multiplier latency is arbitrary, at least 1 cycle. `mm_done` in the same cycle as `mm_start` is illegal.

## Structure
- Package `rsa_pkg`:
  - state encoding localparams;
  - `mm_op` codes (TO_MONT, SQUARE, MULT, FROM_MONT);
  - `N_BITS` default.
- One sub-module: `rsa_bit_cursor`. It holds the `exp_q` register and the `bit_idx` down-counter. Outputs: current bit, `is_last`. Inputs: load, decrement.
- The FSM and output registers stay in `rsa_exp_ctrl`.

## Test plan
- Multiplier model with fixed 5-cycle latency; `exp`=0b1011, `exp_len`=4, `start` at cycle s:
  - `mm_op` sequence is 0,1,2,1,1,2,1,2,3 (9 operations);
  - `done` high only in cycle s+55;
  - `busy` high in cycles s+1..s+55.
- `exp_len`=0, `exp`=all ones → `mm_op` sequence 0,3; `done` at s+13.
- `exp`=0, `exp_len`=1024 → 1026 operations, all squares between TO_MONT and FROM_MONT; final `bit_idx`=0.
- `start` pulsed while busy, and spurious `mm_done` in DONE/IDLE → no change to the operation sequence, no extra `mm_start`.
- Multiplier latency 1 vs. a random 1..20 for `exp`=0xF0 → identical `mm_op` sequences (0,1,2,1,2,1,2,1,2,1,1,1,1,3).
- `resetn` low during SQ_WAIT → all outputs 0 immediately, no `done`. A new `start` after reset runs a full correct sequence.

Source files
------------

// File: rtl/rsa_pkg.sv
// Shared constants for the RSA modular-exponentiation sequencer.
// Latency: none (declarations only).
// Backpressure: not applicable.
package rsa_pkg;

    localparam int N_BITS_DEF = 1024;
    localparam int LEN_W_DEF  = 11;

    // FSM state encodings
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_TOM_WAIT  = 3'd1;
    localparam logic [2:0] ST_SQ_WAIT   = 3'd2;
    localparam logic [2:0] ST_MUL_WAIT  = 3'd3;
    localparam logic [2:0] ST_FROM_WAIT = 3'd4;
    localparam logic [2:0] ST_DONE      = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE      = ST_IDLE,
        S_TOM_WAIT  = ST_TOM_WAIT,
        S_SQ_WAIT   = ST_SQ_WAIT,
        S_MUL_WAIT  = ST_MUL_WAIT,
        S_FROM_WAIT = ST_FROM_WAIT,
        S_DONE      = ST_DONE
    } state_t;

    // Montgomery multiplier operation codes (selects operands and destination)
    localparam logic [1:0] OP_TO_MONT   = 2'd0;  // Xt <= MM(X, R^2)
    localparam logic [1:0] OP_SQUARE    = 2'd1;  // A  <= MM(A, A)
    localparam logic [1:0] OP_MULT      = 2'd2;  // A  <= MM(A, Xt)
    localparam logic [1:0] OP_FROM_MONT = 2'd3;  // A  <= MM(A, 1)

endpackage

// File: rtl/rsa_bit_cursor.sv
// Exponent shadow register plus MSB-first bit index down-counter.
// Latency: load/decrement take effect on the next edge; bit and is_last are combinational from the registers.
// Backpressure: none; the controller only decrements between multiplier operations.
module rsa_bit_cursor #(
    parameter int N_BITS = 1024,
    parameter int LEN_W  = 11
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              i_load,
    input  logic [N_BITS-1:0] i_exp,
    input  logic [LEN_W-1:0]  i_idx,
    input  logic              i_dec,
    output logic              o_bit,
    output logic              o_is_last,
    output logic [LEN_W-1:0]  o_idx
);

    logic [N_BITS-1:0] r_exp_q;
    logic [LEN_W-1:0]  r_idx;
    logic [N_BITS-1:0] w_mask;

    // Capture the exponent on load, otherwise walk the index towards bit 0
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_exp_q <= '0;
            r_idx   <= '0;
        end else if (i_load) begin
            r_exp_q <= i_exp;
            r_idx   <= i_idx;
        end else if (i_dec) begin
            r_idx <= r_idx - LEN_W'(1);
        end
    end

    // A one-hot mask keeps an out-of-range index (zero-length job) harmless
    assign w_mask    = {{(N_BITS-1){1'b0}}, 1'b1} << r_idx;
    assign o_bit     = |(r_exp_q & w_mask);
    assign o_is_last = (r_idx == '0);
    assign o_idx     = r_idx;

endmodule

// File: rtl/rsa_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving a Montgomery multiplier.
// Latency: start -> first mm_start 1 cycle; each mm_done -> next mm_start/done 1 cycle (one bubble per op).
// Backpressure: one op in flight; waits indefinitely for mm_done, ignores start while busy.
module rsa_exp_ctrl
    import rsa_pkg::*;
#(
    parameter int N_BITS = N_BITS_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [N_BITS-1:0] exp,
    input  logic [LEN_W-1:0]  exp_len,
    output logic              busy,
    output logic              done,
    output logic              a_init,
    output logic              mm_start,
    output logic [1:0]        mm_op,
    input  logic              mm_done,
    output logic [LEN_W-1:0]  bit_idx
);

    state_t           r_state;
    logic             r_busy;
    logic             r_done;
    logic             r_a_init;
    logic             r_mm_start;
    logic [1:0]       r_mm_op;
    logic             r_len_zero;

    logic [LEN_W-1:0] w_len_clamp;
    logic [LEN_W-1:0] w_start_idx;
    logic             w_load;
    logic             w_step;
    logic             w_dec;
    logic             w_bit;
    logic             w_is_last;

    // Lengths beyond the exponent width are treated as the full width
    assign w_len_clamp = (exp_len > LEN_W'(N_BITS)) ? LEN_W'(N_BITS) : exp_len;
    // A zero length wraps to all ones; the cursor is never consulted in that case
    assign w_start_idx = w_len_clamp - LEN_W'(1);
    assign w_load      = (r_state == S_IDLE) && start;
    // Step-bit happens after a square on a 0 bit, or after the multiply on a 1 bit
    assign w_step      = mm_done && (((r_state == S_SQ_WAIT) && !w_bit) || (r_state == S_MUL_WAIT));
    assign w_dec       = w_step && !w_is_last;

    rsa_bit_cursor #(
        .N_BITS (N_BITS),
        .LEN_W  (LEN_W)
    ) u_cursor (
        .clk       (clk),
        .resetn    (resetn),
        .i_load    (w_load),
        .i_exp     (exp),
        .i_idx     (w_start_idx),
        .i_dec     (w_dec),
        .o_bit     (w_bit),
        .o_is_last (w_is_last),
        .o_idx     (bit_idx)
    );

    // Sequencer: one multiplier op per WAIT state, outputs registered with the state
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_a_init   <= 1'b0;
            r_mm_start <= 1'b0;
            r_mm_op    <= OP_TO_MONT;
            r_len_zero <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_a_init   <= 1'b0;
            r_mm_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_busy     <= 1'b1;
                        r_a_init   <= 1'b1;
                        r_mm_start <= 1'b1;
                        r_mm_op    <= OP_TO_MONT;
                        r_len_zero <= (exp_len == '0);
                        r_state    <= S_TOM_WAIT;
                    end
                end
                S_TOM_WAIT: begin
                    if (mm_done) begin
                        r_mm_start <= 1'b1;
                        if (r_len_zero) begin
                            r_mm_op <= OP_FROM_MONT;
                            r_state <= S_FROM_WAIT;
                        end else begin
                            r_mm_op <= OP_SQUARE;
                            r_state <= S_SQ_WAIT;
                        end
                    end
                end
                S_SQ_WAIT: begin
                    if (mm_done) begin
                        r_mm_start <= 1'b1;
                        if (w_bit) begin
                            r_mm_op <= OP_MULT;
                            r_state <= S_MUL_WAIT;
                        end else if (w_is_last) begin
                            r_mm_op <= OP_FROM_MONT;
                            r_state <= S_FROM_WAIT;
                        end else begin
                            r_mm_op <= OP_SQUARE;
                            r_state <= S_SQ_WAIT;
                        end
                    end
                end
                S_MUL_WAIT: begin
                    if (mm_done) begin
                        r_mm_start <= 1'b1;
                        if (w_is_last) begin
                            r_mm_op <= OP_FROM_MONT;
                            r_state <= S_FROM_WAIT;
                        end else begin
                            r_mm_op <= OP_SQUARE;
                            r_state <= S_SQ_WAIT;
                        end
                    end
                end
                S_FROM_WAIT: begin
                    if (mm_done) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign a_init   = r_a_init;
    assign mm_start = r_mm_start;
    assign mm_op    = r_mm_op;

endmodule

// File: tb/tb_rsa_exp_ctrl.sv
// Directed bench for rsa_exp_ctrl with a behavioural multiplier of configurable latency.
// Latency: each job observed from start through a few idle cycles after done.
// Backpressure: the multiplier model holds one op at a time and answers after its latency.
module tb_rsa_exp_ctrl;

    localparam int NB = 1024;
    localparam int LW = 11;

    logic          clk;
    logic          resetn;
    logic          start;
    logic [NB-1:0] exp_i;
    logic [LW-1:0] exp_len_i;
    logic          busy;
    logic          done;
    logic          a_init;
    logic          mm_start;
    logic [1:0]    mm_op;
    logic          mm_done;
    logic [LW-1:0] bit_idx;

    rsa_exp_ctrl #(.N_BITS(NB), .LEN_W(LW)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .start    (start),
        .exp      (exp_i),
        .exp_len  (exp_len_i),
        .busy     (busy),
        .done     (done),
        .a_init   (a_init),
        .mm_start (mm_start),
        .mm_op    (mm_op),
        .mm_done  (mm_done),
        .bit_idx  (bit_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [NB-1:0] e;
        logic [LW-1:0] l;
        int            lat;
        bit            rnd;
        int            nops;
        int            nmult;
        int            done_off;
        string         seq;
    } vec_t;

    vec_t vecs[7];

    int n_chk;
    int n_err;
    int cyc;
    int ops[$];
    int cnt_done;
    int cnt_ainit;
    int done_cyc;
    int busy_first;
    int busy_last;
    bit job_ended;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, got, want);
        end
    endtask

    // Drive one job and play the multiplier; optional start/mm_done injection or mid-run reset
    task automatic run_job(input logic [NB-1:0] e, input logic [LW-1:0] l, input int lat,
                           input bit rnd, input bit inj, input bit abort);
        int  pend;
        int  s;
        int  post;
        bit  fin;
        ops.delete();
        cnt_done   = 0;
        cnt_ainit  = 0;
        done_cyc   = -1;
        busy_first = -1;
        busy_last  = -1;
        pend = 0;
        post = 0;
        fin  = 0;
        exp_i     = e;
        exp_len_i = l;
        start     = 1'b1;
        s = cyc;
        for (int k = 0; k < 6000 && !fin; k++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (k == 0) begin
                exp_i     = ~e;
                exp_len_i = ~l;
                start     = 1'b0;
            end else begin
                start = inj && (k == 10);
            end
            mm_done = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    mm_done = 1'b1;
                    chk("mm_op_held", 64'(mm_op), 64'(ops[ops.size()-1]));
                end
            end
            if (mm_start) begin
                chk("mm_start_while_op_pending", 64'(pend), 64'd0);
                ops.push_back(int'(mm_op));
                pend = rnd ? int'($urandom_range(20, 1)) : lat;
            end
            if (a_init) cnt_ainit++;
            if (busy) begin
                if (busy_first < 0) busy_first = cyc - s;
                busy_last = cyc - s;
            end
            if (done) begin
                cnt_done++;
                done_cyc = cyc - s;
            end
            if (inj && done_cyc >= 0 && post < 2) mm_done = 1'b1;
            if (done_cyc >= 0) begin
                post++;
                if (post > 4) fin = 1'b1;
            end
            if (abort && ops.size() == 2 && pend == lat - 2) begin
                #2;
                resetn = 1'b0;
                #1;
                chk("abort_busy", 64'(busy), 64'd0);
                chk("abort_mm_start", 64'(mm_start), 64'd0);
                chk("abort_a_init", 64'(a_init), 64'd0);
                chk("abort_mm_op", 64'(mm_op), 64'd0);
                chk("abort_bit_idx", 64'(bit_idx), 64'd0);
                mm_done = 1'b0;
                for (int j = 0; j < 3; j++) begin
                    @(posedge clk);
                    #1;
                    cyc++;
                    chk("abort_no_done", 64'(done), 64'd0);
                end
                resetn = 1'b1;
                @(posedge clk);
                #1;
                cyc++;
                chk("after_abort_busy", 64'(busy), 64'd0);
                fin = 1'b1;
            end
        end
        mm_done   = 1'b0;
        start     = 1'b0;
        job_ended = fin;
    endtask

    task automatic check_job(input vec_t v, input string tag);
        int nm;
        chk({tag, "_finished"}, 64'(job_ended), 64'd1);
        chk({tag, "_nops"}, 64'(ops.size()), 64'(v.nops));
        for (int i = 0; i < v.seq.len(); i++) begin
            if (i < ops.size())
                chk({tag, "_op_seq"}, 64'(ops[i]), 64'(int'(v.seq[i]) - 48));
        end
        chk({tag, "_last_op"}, (ops.size() > 0) ? 64'(ops[ops.size()-1]) : 64'hFF, 64'd3);
        nm = 0;
        foreach (ops[i]) if (ops[i] == 2) nm++;
        chk({tag, "_mult_count"}, 64'(nm), 64'(v.nmult));
        chk({tag, "_done_pulses"}, 64'(cnt_done), 64'd1);
        chk({tag, "_a_init_pulses"}, 64'(cnt_ainit), 64'd1);
        chk({tag, "_busy_first"}, 64'(busy_first), 64'd1);
        chk({tag, "_busy_last"}, 64'(busy_last), 64'(done_cyc));
        chk({tag, "_busy_idle"}, 64'(busy), 64'd0);
        if (v.done_off != 0) chk({tag, "_done_cycle"}, 64'(done_cyc), 64'(v.done_off));
        if (v.l != '0) chk({tag, "_final_bit_idx"}, 64'(bit_idx), 64'd0);
    endtask

    initial begin
        logic [NB-1:0] top_bit;
        n_chk     = 0;
        n_err     = 0;
        cyc       = 0;
        resetn    = 1'b0;
        start     = 1'b0;
        mm_done   = 1'b0;
        exp_i     = '0;
        exp_len_i = '0;
        job_ended = 1'b0;
        top_bit   = '0;
        top_bit[NB-1] = 1'b1;

        // exp, len, latency, random, ops, mults, done offset, leading op sequence
        vecs[0] = '{1024'hB,  11'd4,    5, 1'b0, 9,    3, 55,   "012112123"};
        vecs[1] = '{'1,       11'd0,    5, 1'b0, 2,    0, 13,   "03"};
        vecs[2] = '{'0,       11'd1024, 1, 1'b0, 1026, 0, 2053, "0111111111111111"};
        vecs[3] = '{1024'hF0, 11'd8,    1, 1'b0, 14,   4, 29,   "01212121211113"};
        vecs[4] = '{1024'hF0, 11'd8,    1, 1'b1, 14,   4, 0,    "01212121211113"};
        vecs[5] = '{top_bit,  11'd2047, 1, 1'b0, 1027, 1, 2055, "0121111111111111"};
        vecs[6] = '{1024'h1,  11'd1,    5, 1'b0, 4,    1, 25,   "0123"};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_a_init", 64'(a_init), 64'd0);
        chk("reset_mm_start", 64'(mm_start), 64'd0);
        chk("reset_mm_op", 64'(mm_op), 64'd0);
        chk("reset_bit_idx", 64'(bit_idx), 64'd0);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        cyc++;

        for (int i = 0; i < 7; i++) begin
            run_job(vecs[i].e, vecs[i].l, vecs[i].lat, vecs[i].rnd, 1'b0, 1'b0);
            check_job(vecs[i], $sformatf("vec%0d", i));
        end

        // Stray start while busy plus spurious mm_done in DONE and IDLE
        run_job(vecs[0].e, vecs[0].l, 5, 1'b0, 1'b1, 1'b0);
        check_job(vecs[0], "inject");

        // Reset asserted while a square is outstanding, then a clean rerun
        run_job(vecs[0].e, vecs[0].l, 5, 1'b0, 1'b0, 1'b1);
        chk("abort_finished", 64'(job_ended), 64'd1);
        chk("abort_done_pulses", 64'(cnt_done), 64'd0);
        run_job(vecs[0].e, vecs[0].l, 5, 1'b0, 1'b0, 1'b0);
        check_job(vecs[0], "rerun");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
